// File: rtl/add_normalise_stage.sv
// ---------------------------------------------------------------------------
// add_normalise_stage: 3-cycle mantissa add, renormalise and IEEE-754 pack.
// Rev 1.0 - define ADDNORM_ROUND_NEAREST_EN for round-to-nearest-even.
// ---------------------------------------------------------------------------
`default_nettype none

module add_normalise_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        idle_Allign,
  input  logic [35:0] cout_Allign,
  input  logic [35:0] zout_Allign,
  input  logic [31:0] sout_Allign,
  output logic        idle_AddNorm,
  output logic [31:0] sout_AddNorm,
  output logic [31:0] result_AddNorm,
  output logic        zero_AddNorm,
  output logic        overflow_AddNorm
);

  localparam logic signed [9:0] EXP_MAX = 10'sd255;

  logic        z_sign, c_sign;
  logic [26:0] z_mant, c_mant;
  logic [27:0] add_sum;
  logic        add_sign;
  logic        unused_c_exp;

  assign z_sign = zout_Allign[35];
  assign c_sign = cout_Allign[35];
  assign z_mant = zout_Allign[26:0];
  assign c_mant = cout_Allign[26:0];
  // C's exponent matches Z's once aligned, so only Z's is carried forward.
  assign unused_c_exp = ^cout_Allign[34:27];

  always_comb begin
    add_sum  = {1'b0, z_mant};
    add_sign = z_sign;
    if (!idle_Allign) begin
      if (z_sign == c_sign) begin
        add_sum = {1'b0, z_mant} + {1'b0, c_mant};
      end else if (z_mant > c_mant) begin
        add_sum = {1'b0, z_mant - c_mant};
      end else if (c_mant > z_mant) begin
        add_sum  = {1'b0, c_mant - z_mant};
        add_sign = c_sign;
      end else begin
        add_sum  = '0;
        add_sign = 1'b0;
      end
    end
  end

  logic        s1_idle;
  logic [31:0] s1_sout;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [27:0] s1_sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_idle <= 1'b1;
      s1_sout <= '0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_sum  <= '0;
    end else begin
      s1_idle <= idle_Allign;
      s1_sout <= sout_Allign;
      s1_sign <= add_sign;
      s1_exp  <= zout_Allign[34:27];
      s1_sum  <= add_sum;
    end
  end

  logic [4:0]        lzc;
  logic              lz_found;
  logic [26:0]       norm_mant;
  logic signed [9:0] norm_exp;
  logic signed [9:0] base_exp;
  logic              norm_zero;

  assign base_exp = signed'({2'b00, s1_exp});

  always_comb begin
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found) begin
        if (s1_sum[i]) lz_found = 1'b1;
        else           lzc = lzc + 5'd1;
      end
    end
  end

  always_comb begin
    norm_mant = s1_sum[26:0];
    norm_exp  = base_exp;
    norm_zero = 1'b0;
    if (!s1_idle) begin
      if (s1_sum[27]) begin
        norm_mant = {s1_sum[27:2], s1_sum[1] | s1_sum[0]};
        norm_exp  = base_exp + 10'sd1;
      end else if (s1_sum == 28'd0) begin
        norm_mant = '0;
        norm_zero = 1'b1;
      end else begin
        norm_mant = s1_sum[26:0] << lzc;
        norm_exp  = base_exp - signed'({5'b00000, lzc});
      end
      // No denormal support: anything at or below exponent zero flushes.
      if (!norm_zero && (norm_exp <= 10'sd0)) begin
        norm_mant = '0;
        norm_zero = 1'b1;
      end
    end
  end

  logic              s2_idle;
  logic [31:0]       s2_sout;
  logic              s2_sign;
  logic signed [9:0] s2_exp;
  logic [26:0]       s2_mant;
  logic              s2_zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_idle <= 1'b1;
      s2_sout <= '0;
      s2_sign <= 1'b0;
      s2_exp  <= '0;
      s2_mant <= '0;
      s2_zero <= 1'b0;
    end else begin
      s2_idle <= s1_idle;
      s2_sout <= s1_sout;
      s2_sign <= s1_sign;
      s2_exp  <= norm_exp;
      s2_mant <= norm_mant;
      s2_zero <= norm_zero;
    end
  end

  logic              round_up;
  logic [24:0]       rounded;
  logic [22:0]       pack_frac;
  logic signed [9:0] pack_exp;

`ifdef ADDNORM_ROUND_NEAREST_EN
  assign round_up = s2_mant[2] & (s2_mant[1] | s2_mant[0] | s2_mant[3]);
`else
  assign round_up = 1'b0;
`endif

  assign rounded = {1'b0, s2_mant[26:3]} + {24'd0, round_up};

  always_comb begin
    pack_frac = rounded[22:0];
    pack_exp  = s2_exp;
    if (rounded[24]) begin
      pack_frac = rounded[23:1];
      pack_exp  = s2_exp + 10'sd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_AddNorm     <= 1'b1;
      sout_AddNorm     <= '0;
      result_AddNorm   <= '0;
      zero_AddNorm     <= 1'b0;
      overflow_AddNorm <= 1'b0;
    end else begin
      idle_AddNorm     <= s2_idle;
      sout_AddNorm     <= s2_sout;
      zero_AddNorm     <= 1'b0;
      overflow_AddNorm <= 1'b0;
      if (s2_idle) begin
        result_AddNorm <= {s2_sign, s2_exp[7:0], s2_mant[25:3]};
      end else if (s2_zero) begin
        result_AddNorm <= {s2_sign, 31'd0};
        zero_AddNorm   <= 1'b1;
      end else if (pack_exp >= EXP_MAX) begin
        result_AddNorm   <= {s2_sign, 8'hFF, 23'd0};
        overflow_AddNorm <= 1'b1;
      end else begin
        result_AddNorm <= {s2_sign, pack_exp[7:0], pack_frac};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_normalise_stage.sv
// ---------------------------------------------------------------------------
// tb_add_normalise_stage: vector table, random model comparison, reset flush.
// Rev 1.0 - honours ADDNORM_ROUND_NEAREST_EN like the design.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_add_normalise_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        idle_Allign = 1'b1;
  logic [35:0] cout_Allign = '0;
  logic [35:0] zout_Allign = '0;
  logic [31:0] sout_Allign = '0;
  logic        idle_AddNorm;
  logic [31:0] sout_AddNorm;
  logic [31:0] result_AddNorm;
  logic        zero_AddNorm;
  logic        overflow_AddNorm;

  add_normalise_stage dut (
    .clock            (clock),
    .reset            (reset),
    .idle_Allign      (idle_Allign),
    .cout_Allign      (cout_Allign),
    .zout_Allign      (zout_Allign),
    .sout_Allign      (sout_Allign),
    .idle_AddNorm     (idle_AddNorm),
    .sout_AddNorm     (sout_AddNorm),
    .result_AddNorm   (result_AddNorm),
    .zero_AddNorm     (zero_AddNorm),
    .overflow_AddNorm (overflow_AddNorm)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        idle;
    logic [31:0] sout;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        idle;
    logic [35:0] z;
    logic [35:0] c;
    logic [31:0] sout;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t pend[$];
  exp_t rst_val;
  vec_t vecs[10];

`ifdef ADDNORM_ROUND_NEAREST_EN
  localparam logic [31:0] RND_SMALL = 32'h3F800002;
  localparam logic [31:0] RND_CARRY = 32'h40000000;
`else
  localparam logic [31:0] RND_SMALL = 32'h3F800001;
  localparam logic [31:0] RND_CARRY = 32'h3FFFFFFF;
`endif

  // Reference model: exact integer arithmetic on the magnitudes.
  function automatic exp_t model(input logic idle, input logic [35:0] z,
                                 input logic [35:0] c, input logic [31:0] s);
    exp_t   r;
    longint zm, cm, mag, q;
    int     e;
    logic   sg;
    r.idle = idle; r.sout = s; r.zero = 1'b0; r.ovf = 1'b0;
    if (idle) begin
      r.result = {z[35], z[34:27], z[25:3]};
      return r;
    end
    zm = {37'd0, z[26:0]};
    cm = {37'd0, c[26:0]};
    e  = {24'd0, z[34:27]};
    if (z[35] == c[35]) begin mag = zm + cm; sg = z[35]; end
    else if (zm > cm)   begin mag = zm - cm; sg = z[35]; end
    else if (cm > zm)   begin mag = cm - zm; sg = c[35]; end
    else                begin mag = 0;       sg = 1'b0;  end
    if (mag == 0) begin
      r.result = {sg, 31'd0}; r.zero = 1'b1;
      return r;
    end
    if (mag >= (64'd1 << 27)) begin
      mag = (mag >> 1) | (mag & 1);
      e = e + 1;
    end
    while (mag < (64'd1 << 26)) begin
      mag = mag << 1;
      e = e - 1;
    end
    if (e <= 0) begin
      r.result = {sg, 31'd0}; r.zero = 1'b1;
      return r;
    end
    q = mag >> 3;
`ifdef ADDNORM_ROUND_NEAREST_EN
    if (((mag >> 2) & 1) == 1 && ((mag & 3) != 0 || ((mag >> 3) & 1) == 1)) q = q + 1;
`endif
    if (q >= (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r.result = {sg, 8'hFF, 23'd0}; r.ovf = 1'b1;
    end else begin
      r.result = {sg, e[7:0], q[22:0]};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk("idle",     {31'd0, idle_AddNorm},     {31'd0, e.idle});
    chk("sout",     sout_AddNorm,              e.sout);
    chk("result",   result_AddNorm,            e.result);
    chk("zero",     {31'd0, zero_AddNorm},     {31'd0, e.zero});
    chk("overflow", {31'd0, overflow_AddNorm}, {31'd0, e.ovf});
  endtask

  // One item per falling edge; the item driven three falling edges earlier is due now.
  task automatic step(input logic idle, input logic [35:0] z, input logic [35:0] c,
                      input logic [31:0] s, input exp_t e);
    @(negedge clock);
    if (pend.size() == 3) check_out(pend.pop_front());
    idle_Allign = idle; zout_Allign = z; cout_Allign = c; sout_Allign = s;
    pend.push_back(e);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    if (pend.size() == 3) check_out(pend.pop_front());
    reset = 1'b1;
    idle_Allign = 1'b1; zout_Allign = '0; cout_Allign = '0; sout_Allign = '0;
    pend.delete();
    repeat (cycles) @(posedge clock);
    @(negedge clock);
    check_out(rst_val);
    reset = 1'b0;
    repeat (3) pend.push_back(rst_val);
  endtask

  function automatic exp_t vexp(input vec_t v);
    exp_t r;
    r.idle = v.idle; r.sout = v.sout; r.result = v.result; r.zero = v.zero; r.ovf = v.ovf;
    return r;
  endfunction

  logic        r_idle, zs, cs;
  logic [7:0]  re;
  logic [26:0] zm, cm;
  logic [31:0] rs;

  initial begin
    rst_val = '{idle: 1'b1, sout: 32'd0, result: 32'd0, zero: 1'b0, ovf: 1'b0};
    vecs[0] = '{1'b0, {1'b0, 8'h7F, 27'h4000000}, {1'b0, 8'h7F, 27'h4000000}, 32'h11111111, 32'h40000000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, {1'b0, 8'h7F, 27'h6000000}, {1'b1, 8'h7F, 27'h4000000}, 32'h22222222, 32'h3F000000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, {1'b0, 8'h7F, 27'h4000000}, {1'b1, 8'h7F, 27'h4000000}, 32'h33333333, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, {1'b0, 8'h7F, 27'h400000C}, {1'b0, 8'h7F, 27'h0000000}, 32'h44444444, RND_SMALL,    1'b0, 1'b0};
    vecs[4] = '{1'b0, {1'b0, 8'hFE, 27'h7FFFFF8}, {1'b0, 8'hFE, 27'h7FFFFF8}, 32'h55555555, 32'h7F800000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, {1'b0, 8'hFF, 27'h4000000}, {1'b0, 8'h00, 27'h0000000}, 32'hA5A5A5A5, 32'h7F800000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, {1'b1, 8'h01, 27'h6000000}, {1'b0, 8'h01, 27'h4000000}, 32'h66666666, 32'h80000000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, {1'b0, 8'h7F, 27'h7FFFFFF}, {1'b0, 8'h7F, 27'h0000000}, 32'h77777777, RND_CARRY,    1'b0, 1'b0};
    vecs[8] = '{1'b0, {1'b1, 8'h80, 27'h4000000}, {1'b1, 8'h80, 27'h4000000}, 32'h88888888, 32'hC0800000, 1'b0, 1'b0};
    vecs[9] = '{1'b0, {1'b1, 8'h7F, 27'h4000000}, {1'b0, 8'h7F, 27'h6000000}, 32'h99999999, 32'h3F000000, 1'b0, 1'b0};

    do_reset(3);

    for (int i = 0; i < 10; i++)
      step(vecs[i].idle, vecs[i].z, vecs[i].c, vecs[i].sout, vexp(vecs[i]));

    for (int n = 0; n < 400; n++) begin
      r_idle = ($urandom_range(0, 9) == 0);
      re = 8'($urandom_range(0, 255));
      zs = 1'($urandom); cs = 1'($urandom);
      zm = 27'($urandom); cm = 27'($urandom);
      rs = $urandom;
      case ($urandom_range(0, 3))
        0: begin zm[26] = 1'b1; cm[26] = 1'b1; end
        1: cm = zm ^ 27'($urandom_range(0, 3));
        2: begin zm[26] = 1'b1; cm = zm >> $urandom_range(0, 27); end
        default: ;
      endcase
      step(r_idle, {zs, re, zm}, {cs, re, cm}, rs,
           model(r_idle, {zs, re, zm}, {cs, re, cm}, rs));
    end

    // Bypass followed by back-to-back items, then reset with two still in flight.
    step(vecs[5].idle, vecs[5].z, vecs[5].c, vecs[5].sout, vexp(vecs[5]));
    step(vecs[0].idle, vecs[0].z, vecs[0].c, vecs[0].sout, vexp(vecs[0]));
    step(vecs[1].idle, vecs[1].z, vecs[1].c, vecs[1].sout, vexp(vecs[1]));
    step(vecs[4].idle, vecs[4].z, vecs[4].c, vecs[4].sout, vexp(vecs[4]));
    step(vecs[2].idle, vecs[2].z, vecs[2].c, vecs[2].sout, vexp(vecs[2]));
    do_reset(1);
    step(vecs[8].idle, vecs[8].z, vecs[8].c, vecs[8].sout, vexp(vecs[8]));
    step(vecs[3].idle, vecs[3].z, vecs[3].c, vecs[3].sout, vexp(vecs[3]));

    repeat (3) step(1'b1, '0, '0, '0, rst_val);
    @(negedge clock);
    check_out(pend.pop_front());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
